// File: rtl/hpi_bus_ctrl.sv
// Purpose: HPI chip-reset sequencer, strobe timer and round-robin arbiter for two requesters.
// Latency: req-sampling edge to done is 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; all outputs registered.
// Backpressure: requests are accepted only in IDLE; a requester keeps req high until its done pulse.
//
// Ports: clk_clk/reset_reset_n (clock, async active-low reset), sw_rst (soft chip reset),
//   a_*/b_* requester ports (req/we/addr/wdata in, gnt/done/rdata out), ready (not in reset),
//   hpi_* pins (addr, cs_n, rd_n, wr_n, rst_n, dout, dout_en out; din in).
module hpi_bus_ctrl #(
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 2,
  parameter int RST_CYC      = 50000,
  parameter int POST_RST_CYC = 1000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        sw_rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic [15:0] b_rdata,
  output logic        ready,
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_rd_n,
  output logic        hpi_wr_n,
  output logic        hpi_rst_n,
  output logic [15:0] hpi_dout,
  output logic        hpi_dout_en,
  input  logic [15:0] hpi_din
);

  localparam int MAX_T1  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_T2  = (MAX_T1 > HOLD_CYC) ? MAX_T1 : HOLD_CYC;
  localparam int MAX_T3  = (MAX_T2 > RST_CYC) ? MAX_T2 : RST_CYC;
  localparam int MAX_ALL = (MAX_T3 > POST_RST_CYC) ? MAX_T3 : POST_RST_CYC;
  localparam int CW      = $clog2(MAX_ALL + 1);

  // Counter load values: a timed state lasts (load + 1) cycles.
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] RST_LD    = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] POST_LD   = CW'(POST_RST_CYC - 1);

  typedef enum logic [2:0] {
    RST_HOLD, RST_WAIT, IDLE, SETUP, STROBE, HOLD, DONE
  } state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           we_q, we_d;
  logic [1:0]     addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  // port_q doubles as the "served last" record for tie-breaking (1 = B).
  logic           port_q, port_d;
  logic           capture;
  logic           busy_d, owned_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= RST_HOLD;
    else                state <= state_d;
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    port_d  = port_q;
    capture = 1'b0;
    case (state)
      RST_HOLD: begin
        if (cnt == '0) begin state_d = RST_WAIT; cnt_d = POST_LD; end
        else cnt_d = cnt - 1'b1;
      end
      RST_WAIT: begin
        if (cnt == '0) state_d = IDLE;
        else cnt_d = cnt - 1'b1;
      end
      IDLE: begin
        if (sw_rst) begin
          state_d = RST_HOLD;
          cnt_d   = RST_LD;
        end else if (a_req && (!b_req || port_q)) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          port_d  = 1'b0;
          we_d    = a_we;
          addr_d  = a_addr;
          wdata_d = a_wdata;
        end else if (b_req) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          port_d  = 1'b1;
          we_d    = b_we;
          addr_d  = b_addr;
          wdata_d = b_wdata;
        end
      end
      SETUP: begin
        if (cnt == '0) begin state_d = STROBE; cnt_d = STROBE_LD; end
        else cnt_d = cnt - 1'b1;
      end
      STROBE: begin
        if (cnt == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          capture = !we_q;  // edge ending the last strobe cycle samples the bus
        end else cnt_d = cnt - 1'b1;
      end
      HOLD: begin
        if (cnt == '0) state_d = DONE;
        else cnt_d = cnt - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = RST_HOLD;
    endcase
  end

  // Outputs are registered from the next state so pins change on the same
  // edge as the state they belong to.
  assign busy_d  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
  assign owned_d = busy_d || (state_d == DONE);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt         <= RST_LD;
      we_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 16'd0;
      port_q      <= 1'b1;
      hpi_rst_n   <= 1'b0;
      hpi_cs_n    <= 1'b1;
      hpi_rd_n    <= 1'b1;
      hpi_wr_n    <= 1'b1;
      hpi_dout_en <= 1'b0;
      hpi_addr    <= 2'd0;
      hpi_dout    <= 16'd0;
      ready       <= 1'b0;
      a_gnt       <= 1'b0;
      b_gnt       <= 1'b0;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      a_rdata     <= 16'd0;
      b_rdata     <= 16'd0;
    end else begin
      cnt         <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      port_q      <= port_d;
      hpi_rst_n   <= (state_d != RST_HOLD);
      ready       <= (state_d != RST_HOLD) && (state_d != RST_WAIT);
      hpi_cs_n    <= !busy_d;
      hpi_rd_n    <= !((state_d == STROBE) && !we_d);
      hpi_wr_n    <= !((state_d == STROBE) && we_d);
      hpi_dout_en <= busy_d && we_d;
      hpi_addr    <= addr_d;
      hpi_dout    <= wdata_d;
      a_gnt       <= owned_d && !port_d;
      b_gnt       <= owned_d && port_d;
      a_done      <= (state_d == DONE) && !port_d;
      b_done      <= (state_d == DONE) && port_d;
      if (capture) begin
        if (port_q) b_rdata <= hpi_din;
        else        a_rdata <= hpi_din;
      end
    end
  end

endmodule

// File: tb/tb_hpi_bus_ctrl.sv
// Directed bench for hpi_bus_ctrl with short reset timing (RST_CYC=8, POST_RST_CYC=4).
// Cycle k means the sample taken 1 time unit after the k-th rising edge following a stimulus change.
module tb_hpi_bus_ctrl;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        sw_rst;
  logic        a_req, a_we, b_req, b_we;
  logic [1:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_done, b_gnt, b_done;
  logic [15:0] a_rdata, b_rdata;
  logic        ready;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n;
  logic [15:0] hpi_dout;
  logic        hpi_dout_en;
  logic [15:0] hpi_din;

  int checks = 0;
  int failures = 0;

  always #5 clk_clk = ~clk_clk;

  hpi_bus_ctrl #(
    .SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(2), .RST_CYC(8), .POST_RST_CYC(4)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .sw_rst(sw_rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .ready(ready), .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n),
    .hpi_wr_n(hpi_wr_n), .hpi_rst_n(hpi_rst_n), .hpi_dout(hpi_dout),
    .hpi_dout_en(hpi_dout_en), .hpi_din(hpi_din)
  );

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Runs one access on a port and records per-cycle pin activity.
  // hpi_din carries din only while rd_n is low, so a mistimed capture reads 16'hDEAD.
  // Returns one idle cycle after done so the controller is back in IDLE.
  task automatic do_access(input bit port, input bit we, input logic [1:0] addr,
                           input logic [15:0] wdata, input logic [15:0] din,
                           output int done_cyc, output logic [31:0] cs_mask,
                           output logic [31:0] wr_mask, output logic [31:0] rd_mask,
                           output bit bus_bad, output bit other_done,
                           output logic [15:0] rdata_at_done);
    done_cyc = 0; cs_mask = '0; wr_mask = '0; rd_mask = '0;
    bus_bad = 0; other_done = 0; rdata_at_done = 16'h0;
    hpi_din = 16'hDEAD;
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
    for (int k = 1; k <= 30 && done_cyc == 0; k++) begin
      tick();
      if (hpi_cs_n === 1'b0) cs_mask[k[4:0]] = 1'b1;
      if (hpi_wr_n === 1'b0) wr_mask[k[4:0]] = 1'b1;
      if (hpi_rd_n === 1'b0) rd_mask[k[4:0]] = 1'b1;
      if (hpi_cs_n === 1'b0 && hpi_addr !== addr) bus_bad = 1;
      if (hpi_cs_n === 1'b0 && we && (hpi_dout_en !== 1'b1 || hpi_dout !== wdata)) bus_bad = 1;
      if (!we && hpi_dout_en !== 1'b0) bus_bad = 1;
      hpi_din = (hpi_rd_n === 1'b0) ? din : 16'hDEAD;
      if ((port ? a_done : b_done) === 1'b1) other_done = 1;
      if ((port ? b_done : a_done) === 1'b1) begin
        done_cyc = k;
        rdata_at_done = port ? b_rdata : a_rdata;
      end
    end
    a_req = 0; b_req = 0;
    tick();
  endtask

  task automatic test_reset();
    int rise_k, ready_k, gnt_k, done_k;
    logic [15:0] rd_at_done;
    reset_reset_n = 0; sw_rst = 0;
    a_req = 1; a_we = 0; a_addr = 2'd0; a_wdata = 16'h0;
    b_req = 0; b_we = 0; b_addr = 2'd0; b_wdata = 16'h0;
    hpi_din = 16'h0F0F;
    repeat (2) tick();
    checks++;
    if ({hpi_rst_n, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_dout_en} !== 5'b01110) begin
      failures++; $display("FAIL reset_strobes got=%b want=01110",
                           {hpi_rst_n, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_dout_en});
    end
    checks++;
    if ({hpi_addr, hpi_dout} !== 18'h0) begin
      failures++; $display("FAIL reset_bus got=%h want=0", {hpi_addr, hpi_dout});
    end
    checks++;
    if ({a_gnt, b_gnt, a_done, b_done, ready} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=00000", {a_gnt, b_gnt, a_done, b_done, ready});
    end
    checks++;
    if ({a_rdata, b_rdata} !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h want=0", {a_rdata, b_rdata});
    end
    reset_reset_n = 1;
    rise_k = 0; ready_k = 0; gnt_k = 0; done_k = 0; rd_at_done = 16'h0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      tick();
      if (hpi_rst_n === 1'b1 && rise_k == 0) rise_k = k;
      if (ready === 1'b1 && ready_k == 0) ready_k = k;
      if (a_gnt === 1'b1 && gnt_k == 0) gnt_k = k;
      if (a_done === 1'b1) begin done_k = k; rd_at_done = a_rdata; a_req = 0; end
    end
    a_req = 0;
    tick();
    checks++;
    if (rise_k != 8) begin failures++; $display("FAIL pwr_rst_rise got=%0d want=8", rise_k); end
    checks++;
    if (ready_k != 12) begin failures++; $display("FAIL pwr_ready got=%0d want=12", ready_k); end
    checks++;
    if (gnt_k != 13) begin failures++; $display("FAIL pwr_first_gnt got=%0d want=13", gnt_k); end
    checks++;
    if (done_k != 21) begin failures++; $display("FAIL pwr_done got=%0d want=21", done_k); end
    checks++;
    if (rd_at_done !== 16'h0F0F) begin
      failures++; $display("FAIL pwr_rdata got=%h want=0f0f", rd_at_done);
    end
  endtask

  task automatic test_write_a();
    int dc; logic [31:0] cs, wr, rd; bit bad, oth; logic [15:0] rv;
    do_access(1'b0, 1'b1, 2'd2, 16'hBEEF, 16'h0, dc, cs, wr, rd, bad, oth, rv);
    checks++;
    if (dc != 9) begin failures++; $display("FAIL wr_done_cyc got=%0d want=9", dc); end
    checks++;
    if (cs !== 32'h1FE) begin failures++; $display("FAIL wr_cs_mask got=%h want=000001fe", cs); end
    checks++;
    if (wr !== 32'h78 || rd !== 32'h0) begin
      failures++; $display("FAIL wr_strobe got=wr%h rd%h want=wr00000078 rd00000000", wr, rd);
    end
    checks++;
    if (bad) begin failures++; $display("FAIL wr_bus got=bad want=addr2_dout_beef_en1"); end
    checks++;
    if (oth) begin failures++; $display("FAIL wr_b_done got=1 want=0"); end
    checks++;
    if (a_rdata !== 16'h0F0F) begin failures++; $display("FAIL wr_a_rdata got=%h want=0f0f", a_rdata); end
  endtask

  task automatic test_read_b();
    int dc; logic [31:0] cs, wr, rd; bit bad, oth; logic [15:0] rv;
    do_access(1'b1, 1'b0, 2'd1, 16'h0, 16'h1234, dc, cs, wr, rd, bad, oth, rv);
    checks++;
    if (dc != 9) begin failures++; $display("FAIL rd_done_cyc got=%0d want=9", dc); end
    checks++;
    if (cs !== 32'h1FE || rd !== 32'h78 || wr !== 32'h0) begin
      failures++; $display("FAIL rd_strobe got=cs%h rd%h wr%h want=cs1fe rd78 wr0", cs, rd, wr);
    end
    checks++;
    if (rv !== 16'h1234) begin failures++; $display("FAIL rd_b_rdata got=%h want=1234", rv); end
    checks++;
    if (bad || oth) begin failures++; $display("FAIL rd_side got=bad%0d a_done%0d want=0 0", bad, oth); end
    checks++;
    if (a_rdata !== 16'h0F0F) begin failures++; $display("FAIL rd_a_rdata got=%h want=0f0f", a_rdata); end
  endtask

  task automatic test_back_to_back();
    int n_done, hi_run, min_gap, max_gap, last_k;
    logic [3:0] order;
    bit viol;
    n_done = 0; hi_run = 0; min_gap = 99; max_gap = 0; last_k = 0; order = 4'h0; viol = 0;
    a_we = 1; a_addr = 2'd3; a_wdata = 16'h1111;
    b_we = 0; b_addr = 2'd0; b_wdata = 16'h0;
    hpi_din = 16'h7777;
    a_req = 1; b_req = 1;
    for (int k = 1; k <= 60 && n_done < 4; k++) begin
      tick();
      if (hpi_rd_n === 1'b0 && hpi_wr_n === 1'b0) viol = 1;
      if ((hpi_rd_n === 1'b0 || hpi_wr_n === 1'b0) && (hpi_cs_n !== 1'b0 || hpi_rst_n !== 1'b1)) viol = 1;
      if (a_gnt === 1'b1 && b_gnt === 1'b1) viol = 1;
      if (hpi_cs_n === 1'b1) hi_run++;
      else begin
        if (n_done > 0 && hi_run > 0) begin
          if (hi_run < min_gap) min_gap = hi_run;
          if (hi_run > max_gap) max_gap = hi_run;
        end
        hi_run = 0;
      end
      if (a_done === 1'b1 || b_done === 1'b1) begin
        order[n_done[1:0]] = b_done;
        n_done++;
        last_k = k;
      end
    end
    a_req = 0; b_req = 0;
    tick();
    checks++;
    if (n_done != 4 || order !== 4'b1010) begin
      failures++; $display("FAIL alt_order got=n%0d order%b want=n4 order1010", n_done, order);
    end
    checks++;
    if (last_k != 39) begin failures++; $display("FAIL alt_last_done got=%0d want=39", last_k); end
    checks++;
    if (min_gap != 2 || max_gap != 2) begin
      failures++; $display("FAIL alt_cs_gap got=min%0d max%0d want=2 2", min_gap, max_gap);
    end
    checks++;
    if (viol) begin failures++; $display("FAIL alt_protocol got=violation want=none"); end
    checks++;
    if (b_rdata !== 16'h7777 || a_rdata !== 16'h0F0F) begin
      failures++; $display("FAIL alt_rdata got=a%h b%h want=a0f0f b7777", a_rdata, b_rdata);
    end
  endtask

  task automatic test_sw_rst();
    int rise_k, ready_k, gnt_k, done_k;
    bit early_bad;
    rise_k = 0; ready_k = 0; gnt_k = 0; done_k = 0; early_bad = 0;
    hpi_din = 16'h4321;
    b_we = 0; b_addr = 2'd2; b_req = 1; sw_rst = 1;
    tick();
    sw_rst = 0;
    checks++;
    if (hpi_rst_n !== 1'b0 || ready !== 1'b0 || b_gnt !== 1'b0) begin
      failures++; $display("FAIL swr_enter got=rst_n%b ready%b gnt%b want=0 0 0", hpi_rst_n, ready, b_gnt);
    end
    for (int k = 2; k <= 40 && done_k == 0; k++) begin
      tick();
      if (hpi_rst_n === 1'b1 && rise_k == 0) rise_k = k;
      if (ready === 1'b1 && ready_k == 0) ready_k = k;
      if (b_gnt === 1'b1 && gnt_k == 0) gnt_k = k;
      if (hpi_cs_n === 1'b0 && ready_k == 0) early_bad = 1;
      if (b_done === 1'b1) begin done_k = k; b_req = 0; end
    end
    b_req = 0;
    tick();
    checks++;
    if (rise_k != 9 || ready_k != 13) begin
      failures++; $display("FAIL swr_seq got=rise%0d ready%0d want=9 13", rise_k, ready_k);
    end
    checks++;
    if (gnt_k != 14 || done_k != 22 || early_bad) begin
      failures++; $display("FAIL swr_b got=gnt%0d done%0d early%0d want=14 22 0", gnt_k, done_k, early_bad);
    end
    checks++;
    if (b_rdata !== 16'h4321) begin failures++; $display("FAIL swr_rdata got=%h want=4321", b_rdata); end
  endtask

  task automatic test_reset_mid_strobe();
    bit done_seen;
    done_seen = 0;
    hpi_din = 16'h0;
    a_we = 1; a_addr = 2'd3; a_wdata = 16'hCAFE; a_req = 1;
    repeat (4) tick();
    checks++;
    if (hpi_wr_n !== 1'b0 || hpi_cs_n !== 1'b0 || hpi_dout !== 16'hCAFE) begin
      failures++; $display("FAIL mid_pre got=wr%b cs%b dout%h want=0 0 cafe", hpi_wr_n, hpi_cs_n, hpi_dout);
    end
    reset_reset_n = 0;
    a_req = 0;
    #1;
    checks++;
    if ({hpi_wr_n, hpi_cs_n, hpi_dout_en, hpi_rst_n, a_gnt, ready} !== 6'b110000) begin
      failures++; $display("FAIL mid_abort got=%b want=110000",
                           {hpi_wr_n, hpi_cs_n, hpi_dout_en, hpi_rst_n, a_gnt, ready});
    end
    for (int k = 0; k < 15; k++) begin
      if (k == 3) reset_reset_n = 1;
      tick();
      if (a_done === 1'b1 || b_done === 1'b1) done_seen = 1;
    end
    checks++;
    if (done_seen) begin failures++; $display("FAIL mid_no_done got=pulse want=none"); end
    checks++;
    if ({a_rdata, b_rdata} !== 32'h0) begin
      failures++; $display("FAIL mid_rdata got=%h want=0", {a_rdata, b_rdata});
    end
  endtask

  initial begin
    test_reset();
    test_write_a();
    test_read_b();
    test_back_to_back();
    test_sw_rst();
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpi_bus_ctrl.md
# hpi_bus_ctrl

Hardware sequencer and two-port arbiter for the EZ-OTG host port interface (HPI). It generates the chip reset sequence and the chip-select/read/write strobe timing, and it drives the tri-state data bus. It shares the HPI between the CPU-side requester (port A) and a hardware keyboard poller (port B). It sits between those requesters and the top-level OTG pins, replacing software bit-banging of the HPI PIO exports.

## Interface
- SETUP_CYC, 2: cycles CS/address/write data are valid before the strobe (≥1)
- STROBE_CYC, 4: cycles RD_N/WR_N are held low (≥1)
- HOLD_CYC, 2: cycles CS/address/write data are held after the strobe (≥1)
- RST_CYC, 50000: cycles hpi_rst_n is held low after reset or soft reset (≥1)
- POST_RST_CYC, 1000: wait cycles after hpi_rst_n rises, before the first access (≥1)

Ports:
- clk_clk  in  1  system clock; all logic is on the rising edge
- reset_reset_n  in  1  asynchronous, active-low reset
- sw_rst  in  1  soft chip-reset request, sampled only in IDLE
- a_req, b_req  in  1  access request; held high with fields stable until the matching done
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  2  HPI register select
- a_wdata, b_wdata  in  16  write data
- a_gnt, b_gnt  out  1  high from SETUP through DONE while that port owns the bus
- a_done, b_done  out  1  one-cycle completion pulse
- a_rdata, b_rdata  out  16  read data; valid when done is high; held until that port's next read completes
- ready  out  1  high in every non-reset state
- hpi_addr  out  2  HPI address
- hpi_cs_n, hpi_rd_n, hpi_wr_n  out  1  active-low strobes
- hpi_rst_n  out  1  active-low chip reset
- hpi_dout  out  16  bus write data
- hpi_dout_en  out  1  tri-state enable for hpi_dout
- hpi_din  in  16  bus read data

## Operation
- States: RST_HOLD, RST_WAIT, IDLE, SETUP, STROBE, HOLD, DONE.
- RST_HOLD: hpi_rst_n=0 for RST_CYC cycles, then go to RST_WAIT.
- RST_WAIT: hpi_rst_n=1 for POST_RST_CYC cycles, then go to IDLE.
- IDLE priority order:
  - sw_rst goes to RST_HOLD.
  - A single request is granted.
  - If a_req and b_req are both high, grant the port not served last. After reset, "last" = B, so A wins the first tie.
- On grant, latch we/addr/wdata/port and go to SETUP.
- SETUP: hpi_cs_n=0 and hpi_addr driven. On writes, hpi_dout_en=1 and hpi_dout = latched data.
- STROBE: hpi_rd_n=0 (read) or hpi_wr_n=0 (write). On the last STROBE cycle, a read registers hpi_din into the granted port's rdata.
- HOLD: both strobes are high; CS, address and write data are unchanged.
- DONE: hpi_cs_n=1, hpi_dout_en=0. The granted done is 1 for exactly one cycle. Next state is IDLE.
- Requests are ignored outside IDLE. They are not lost; the requester keeps req high. A req still high in IDLE after its done is a new transaction.
- The ungranted port's outputs are unaffected by the other port's transaction.
- A single down-counter is shared by all timed states. Its width is sized to the largest parameter.

## Timing
- Reset values, applied asynchronously:
  - state = RST_HOLD
  - hpi_rst_n=0, hpi_cs_n=1, hpi_rd_n=1, hpi_wr_n=1
  - hpi_dout_en=0, hpi_addr=0, hpi_dout=0
  - gnt=0, done=0, rdata=0, ready=0
- Reset mid-transaction aborts immediately to these values. There is no partial strobe and no done pulse.
- Latency from the req-sampling edge (IDLE) to done: 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles. With defaults, done is high in cycle 9.
- hpi_cs_n is high for at least 2 cycles (DONE + IDLE) between back-to-back accesses.
- Write data is valid across SETUP+STROBE+HOLD, so it brackets hpi_wr_n on both sides.
- The read capture edge is the edge ending the last STROBE cycle.
- hpi_rd_n and hpi_wr_n are never low together. Neither is low while hpi_cs_n=1 or hpi_rst_n=0.
- All outputs are registered.

## Test plan
- Power-up, with RST_CYC=8 and POST_RST_CYC=4: hpi_rst_n low for 8 cycles, then high. ready rises 4 cycles later. a_req held during reset is served only after ready.
- Write A, addr=2, wdata=0xBEEF: cs_n low 8 cycles. wr_n low exactly cycles 3–6. dout_en and dout=0xBEEF throughout. a_done in cycle 9. b_done stays 0.
- Read B, addr=1, with hpi_din=0x1234 during STROBE: rd_n low for 4 cycles. b_rdata=0x1234 when b_done=1. a_rdata is unchanged.
- a_req and b_req held high continuously: grants alternate A, B, A, B. Each done is followed by at least 2 cs_n-high cycles.
- sw_rst pulse in IDLE while b_req is high: re-enters RST_HOLD. B completes only after the new reset sequence.
- reset_reset_n asserted mid-STROBE of a write: wr_n, cs_n and dout_en deassert immediately. hpi_rst_n=0. No done pulse occurs.
